// File: rtl/minterm_lut.sv
// minterm_lut: a runtime-reloadable N_IN-input boolean function.
//
// The active truth table (bit k = f(minterm k)) answers evaluation requests
// through a 1-deep registered valid/ready stage. A new table is shifted in
// serially into a shadow register while evaluation continues. It then
// replaces the active table in a single COMMIT cycle.
//
// Optional feature: define MINTERM_COUNT_EN to add the true_count output.
// It is a registered popcount of the active table.
//
// Parameters:
//   N_IN  number of function inputs (2..8); table depth D = 2**N_IN
//   INIT  truth table loaded at reset
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid/in_vec  evaluation request; in_vec is the minterm index
//   in_ready         request accepted this cycle
//   out_valid/out_f  registered function value for the accepted index
//   out_ready        consumer takes out_f this cycle
//   cfg_start        begin a table load (only honoured when idle)
//   cfg_bit_valid    cfg_bit carries the next table bit, MSB (minterm D-1) first
//   cfg_abort        abandon a load that is still shifting
//   cfg_busy         load in progress (SHIFT or COMMIT)
//   cfg_done         one-cycle pulse while the new table is being committed
//   true_count       (MINTERM_COUNT_EN only) number of 1s in the active table

module minterm_lut #(
  parameter int N_IN = 4,
  parameter logic [(1<<N_IN)-1:0] INIT = 16'hAA45
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_vec,
  output logic            in_ready,
  output logic            out_valid,
  output logic            out_f,
  input  logic            out_ready,
  input  logic            cfg_start,
  input  logic            cfg_bit_valid,
  input  logic            cfg_bit,
  input  logic            cfg_abort,
  output logic            cfg_busy,
  output logic            cfg_done
`ifdef MINTERM_COUNT_EN
  ,
  output logic [N_IN:0]   true_count
`endif
);

  localparam int D = 1 << N_IN;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  state_t          state;
  logic [D-1:0]    active_tbl;
  logic [D-1:0]    shadow;
  logic [N_IN-1:0] cnt;

  // The output register can take a new request whenever it is empty or is
  // being drained in the same cycle.
  assign in_ready = !out_valid || out_ready;

  // Evaluation stage. It never looks at the load FSM. A request accepted in
  // the COMMIT cycle therefore reads the old table, because active_tbl only
  // changes at the end of that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_f     <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_f     <= active_tbl[in_vec];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Table load FSM.
  // Bits arrive MSB first, so bit number cnt belongs at index D-1-cnt. With
  // an N_IN-bit counter that index is simply ~cnt. The D-th bit is the one
  // that arrives with cnt all ones. cfg_done and cfg_busy are registered
  // alongside the state, so both are high exactly during COMMIT. cfg_busy is
  // also high throughout SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shadow     <= '0;
      active_tbl <= INIT;
      cfg_busy   <= 1'b0;
      cfg_done   <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            state    <= SHIFT;
            cnt      <= '0;
            cfg_busy <= 1'b1;
          end
        end
        SHIFT: begin
          // Abort wins over a bit arriving in the same cycle.
          if (cfg_abort) begin
            state    <= IDLE;
            cnt      <= '0;
            shadow   <= '0;
            cfg_busy <= 1'b0;
          end else if (cfg_bit_valid) begin
            shadow[~cnt] <= cfg_bit;
            cnt          <= cnt + 1'b1;
            if (cnt == '1) begin
              state    <= COMMIT;
              cfg_done <= 1'b1;
            end
          end
        end
        COMMIT: begin
          active_tbl <= shadow;
          state      <= IDLE;
          cnt        <= '0;
          cfg_busy   <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          cfg_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef MINTERM_COUNT_EN
  function automatic logic [N_IN:0] popcount(input logic [D-1:0] v);
    logic [N_IN:0] c;
    c = '0;
    for (int i = 0; i < D; i++) begin
      c = c + {{N_IN{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // The count is loaded on the same edge that commits the table. The new
  // count therefore appears the cycle after cfg_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      true_count <= popcount(INIT);
    end else if (state == COMMIT) begin
      true_count <= popcount(shadow);
    end
  end
`endif

endmodule

// File: tb/tb_minterm_lut.sv
// Testbench for minterm_lut (N_IN=4, INIT=16'hAA45).
// It drives evaluation requests and serial table loads. Expected function
// values are pushed to a scoreboard queue on acceptance. They are popped and
// compared when the output handshake completes. The handshake timing of
// out_valid and in_ready is tracked independently of the DUT.
// When the design is built with MINTERM_COUNT_EN, true_count is also checked.

`timescale 1ns/1ps

module tb_minterm_lut;

  localparam int N_IN = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic [N_IN-1:0] in_vec = '0;
  logic            in_ready;
  logic            out_valid;
  logic            out_f;
  logic            out_ready = 1'b0;
  logic            cfg_start = 1'b0;
  logic            cfg_bit_valid = 1'b0;
  logic            cfg_bit = 1'b0;
  logic            cfg_abort = 1'b0;
  logic            cfg_busy;
  logic            cfg_done;
`ifdef MINTERM_COUNT_EN
  logic [N_IN:0]   true_count;
`endif

  int   n_cmp = 0;
  int   n_fail = 0;
  logic sb[$];
  logic cur_exp = 1'b0;
  logic exp_valid = 1'b0;
  logic acc;
  logic exp_bit;

  typedef struct {
    logic [N_IN-1:0] vec;
    logic            exp_f;
  } vec_t;

  vec_t vectors[16];

  minterm_lut #(
    .N_IN(N_IN),
    .INIT(16'hAA45)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_vec       (in_vec),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_f        (out_f),
    .out_ready    (out_ready),
    .cfg_start    (cfg_start),
    .cfg_bit_valid(cfg_bit_valid),
    .cfg_bit      (cfg_bit),
    .cfg_abort    (cfg_abort),
    .cfg_busy     (cfg_busy),
    .cfg_done     (cfg_done)
`ifdef MINTERM_COUNT_EN
    ,
    .true_count   (true_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N_IN-1:0] vec, input logic exp_f);
    in_valid = 1'b1;
    in_vec   = vec;
    cur_exp  = exp_f;
    tick();
  endtask

  task automatic idleCycles(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  // Handshake monitor. It runs at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_valid = 1'b0;
    end else begin
      checkOutput("out_valid", out_valid, exp_valid);
      checkOutput("in_ready", in_ready, !exp_valid || out_ready);
      acc = in_valid && (!exp_valid || out_ready);
      if (exp_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL sb_underflow: got out_f=%0b, expected no output", out_f);
        end else begin
          exp_bit = sb.pop_front();
          checkOutput("out_f", out_f, exp_bit);
        end
      end
      if (acc) sb.push_back(cur_exp);
      exp_valid = acc || (exp_valid && !out_ready);
    end
  end

  initial begin : main
    logic [15:0] pat;

    for (int i = 0; i < 16; i++) begin
      vectors[i].vec   = 4'(i);
      vectors[i].exp_f = (i inside {0, 2, 6, 9, 11, 13, 15});
    end

    // Reset state.
    #3;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_f", out_f, 0);
    checkOutput("rst_cfg_busy", cfg_busy, 0);
    checkOutput("rst_cfg_done", cfg_done, 0);
    checkOutput("rst_in_ready", in_ready, 1);
`ifdef MINTERM_COUNT_EN
    checkOutput("rst_true_count", true_count, 7);
`endif
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();

    // Full sweep of the reset table.
    $display("[TB] sweep of INIT table");
    for (int i = 0; i < 16; i++) applyStimulus(vectors[i].vec, vectors[i].exp_f);
    idleCycles(2);

    // Backpressure: the output holds and the new request waits.
    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(4'd6, 1'b1);
    in_valid = 1'b1;
    in_vec   = 4'd1;
    cur_exp  = 1'b0;
    repeat (3) tick();
    checkOutput("hold_out_f", out_f, 1);
    checkOutput("hold_out_valid", out_valid, 1);
    checkOutput("hold_in_ready", in_ready, 0);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checkOutput("released_out_f", out_f, 0);
    idleCycles(2);

    // Abort after 7 bits. The active table must be untouched.
    $display("[TB] abort mid-load");
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    checkOutput("abort_busy_shift", cfg_busy, 1);
    for (int k = 0; k < 7; k++) begin
      cfg_bit_valid = 1'b1;
      cfg_bit       = 1'b1;
      tick();
    end
    cfg_abort = 1'b1;
    tick();
    cfg_abort     = 1'b0;
    cfg_bit_valid = 1'b0;
    checkOutput("abort_busy_low", cfg_busy, 0);
    checkOutput("abort_no_done", cfg_done, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("abort_no_done_later", cfg_done, 0);
    end
    applyStimulus(4'd6, 1'b1);
    applyStimulus(4'd1, 1'b0);
    applyStimulus(4'd14, 1'b0);
    applyStimulus(4'd15, 1'b1);
    idleCycles(2);
`ifdef MINTERM_COUNT_EN
    checkOutput("abort_true_count", true_count, 7);
`endif

    // Full load of 16'h8001. cfg_start is held through the first bits and must be ignored.
    $display("[TB] load 16'h8001");
    pat = 16'h8001;
    cfg_start = 1'b1;
    tick();
    for (int i = 15; i >= 0; i--) begin
      if (i == 12) cfg_start = 1'b0;
      if (i == 8) begin
        checkOutput("load_busy_mid", cfg_busy, 1);
        checkOutput("load_done_mid", cfg_done, 0);
      end
      cfg_bit_valid = 1'b1;
      cfg_bit       = pat[i];
      tick();
    end
    cfg_bit_valid = 1'b0;
    checkOutput("load_done_pulse", cfg_done, 1);
    checkOutput("load_busy_commit", cfg_busy, 1);
    tick();
    checkOutput("load_done_cleared", cfg_done, 0);
    checkOutput("load_busy_cleared", cfg_busy, 0);
`ifdef MINTERM_COUNT_EN
    checkOutput("load_true_count", true_count, 2);
`endif
    applyStimulus(4'd15, 1'b1);
    applyStimulus(4'd0, 1'b1);
    applyStimulus(4'd2, 1'b0);
    applyStimulus(4'd14, 1'b0);
    idleCycles(2);

    // Load 16'h0000. A request in the COMMIT cycle sees the old table.
    $display("[TB] commit-cycle request");
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cfg_bit_valid = 1'b1;
      cfg_bit       = 1'b0;
      tick();
    end
    cfg_bit_valid = 1'b0;
    checkOutput("zero_done_pulse", cfg_done, 1);
    applyStimulus(4'd0, 1'b1);
    applyStimulus(4'd0, 1'b0);
    idleCycles(2);
`ifdef MINTERM_COUNT_EN
    checkOutput("zero_true_count", true_count, 0);
`endif

    // Reset during a load, with an output stalled and bits still arriving.
    $display("[TB] reset mid-load");
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cfg_bit_valid = 1'b1;
      cfg_bit       = 1'b1;
      if (k == 0) begin
        in_valid = 1'b1;
        in_vec   = 4'd3;
        cur_exp  = 1'b0;
      end
      tick();
      in_valid = 1'b0;
    end
    checkOutput("pre_rst_busy", cfg_busy, 1);
    checkOutput("pre_rst_out_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("async_rst_busy", cfg_busy, 0);
    checkOutput("async_rst_out_valid", out_valid, 0);
    checkOutput("async_rst_done", cfg_done, 0);
    checkOutput("async_rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      tick();
      if (k % 6 == 5) checkOutput("post_rst_idle", cfg_busy, 0);
    end
    cfg_bit_valid = 1'b0;
    applyStimulus(4'd0, 1'b1);
    applyStimulus(4'd1, 1'b0);
    applyStimulus(4'd6, 1'b1);
    applyStimulus(4'd9, 1'b1);
    applyStimulus(4'd14, 1'b0);
    applyStimulus(4'd15, 1'b1);
    idleCycles(3);
`ifdef MINTERM_COUNT_EN
    checkOutput("post_rst_true_count", true_count, 7);
`endif

    checkOutput("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/minterm_lut.md
MINTERM_LUT -- requirements
Module: minterm_lut

Interface
REQ-001 The block SHALL have parameter N_IN, default 4, meaning number of function inputs (legal 2..8); table depth D = 2^N_IN.
REQ-002 The block SHALL have parameter INIT, width D, default 16'hAA45, meaning the truth table loaded at reset (bit k = f(minterm k)).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1, meaning in_vec carries an evaluation request.
REQ-006 The block SHALL have port in_vec, input, N_IN, meaning the minterm index; bit N_IN-1 is the MSB (variable a).
REQ-007 The block SHALL have port in_ready, output, 1, meaning an evaluation request is accepted this cycle.
REQ-008 The block SHALL have port out_valid, output, 1, meaning out_f is valid.
REQ-009 The block SHALL have port out_f, output, 1, meaning function value for the accepted in_vec.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the consumer takes out_f this cycle.
REQ-011 The block SHALL have port cfg_start, input, 1, meaning request a new table load.
REQ-012 The block SHALL have port cfg_bit_valid, input, 1, meaning cfg_bit is valid this cycle.
REQ-013 The block SHALL have port cfg_bit, input, 1, meaning serial table bit, MSB (minterm D-1) first.
REQ-014 The block SHALL have port cfg_abort, input, 1, meaning abandon a load in progress.
REQ-015 The block SHALL have port cfg_busy, output, 1, meaning a load is in SHIFT or COMMIT.
REQ-016 The block SHALL have port cfg_done, output, 1, meaning one-cycle pulse when a new table becomes active.

Function
REQ-017 Evaluation SHALL be a 1-deep registered stage: in_ready = !out_valid | out_ready; on in_valid & in_ready, out_f <= active[in_vec] and out_valid <= 1 the next cycle (latency 1).
REQ-018 out_valid SHALL clear when out_ready is high and no new request is accepted; out_f and out_valid SHALL hold while out_valid & !out_ready.
REQ-019 The load FSM SHALL have states IDLE, SHIFT, COMMIT; cfg_busy is high in SHIFT and COMMIT.
REQ-020 In IDLE, cfg_start SHALL move to SHIFT with the bit counter cleared; cfg_start in SHIFT or COMMIT SHALL be ignored.
REQ-021 In SHIFT, each cycle with cfg_bit_valid SHALL write cfg_bit to shadow[D-1-cnt] and increment cnt; after the D-th bit the FSM SHALL move to COMMIT.
REQ-022 In COMMIT (exactly one cycle) the active table SHALL be replaced atomically by shadow, cfg_done SHALL pulse high, and the FSM SHALL return to IDLE.
REQ-023 cfg_abort in SHIFT SHALL return to IDLE next cycle, discarding shadow and leaving the active table unchanged; cfg_abort takes priority over cfg_bit_valid in that cycle; in IDLE/COMMIT cfg_abort SHALL be ignored.
REQ-024 Evaluation SHALL never stall for loading; a request accepted in the COMMIT cycle SHALL use the old table; the next cycle onward SHALL use the new table.

Reset
REQ-025 On rst_n low, immediately and independent of clk: active table = INIT, shadow = 0, FSM = IDLE, cnt = 0, out_valid = 0, out_f = 0, cfg_done = 0, cfg_busy = 0.
REQ-026 Reset asserted mid-load SHALL discard the partial load; the table after reset is INIT, not the partial shadow.

Configuration
REQ-027 With macro MINTERM_COUNT_EN defined, the block SHALL add output port true_count (width N_IN+1) = number of 1 bits in the active table; registered; equals popcount(INIT) after reset; updates the cycle after cfg_done.
REQ-028 Without MINTERM_COUNT_EN the true_count port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-029 Reset with N_IN=4, INIT=16'hAA45; sweep in_vec 0..15 with out_ready=1 -> out_f=1 exactly for 0,2,6,9,11,13,15, each 1 cycle after acceptance.
REQ-030 Hold out_ready=0 with out_valid=1, drive in_valid with in_vec=1 -> in_ready=0, out_f/out_valid held; release out_ready -> vector 1 accepted, out_f=0 next cycle.
REQ-031 cfg_start, then 16 bits of 16'h8001 -> cfg_done pulses one cycle after the 16th bit; in_vec 15 and 0 give 1, in_vec 2 gives 0; true_count=2 when MINTERM_COUNT_EN is defined.
REQ-032 cfg_start, 7 bits, cfg_abort -> cfg_busy drops next cycle, no cfg_done, table still 16'hAA45 (in_vec 6 gives 1).
REQ-033 Request in_vec=0 accepted in the COMMIT cycle of a 16'h0000 load -> out_f=1 (old table); same request one cycle later -> out_f=0.
REQ-034 Assert rst_n low after 10 load bits and hold cfg_bit_valid -> cfg_busy=0 and out_valid=0 immediately; after release, table = 16'hAA45 and the FSM is IDLE.
